obi_ahb_bridge: RTL and testbench

Parametrised two-port OBI (req/gnt/rvalid) to AHB-Lite master bridge between the Ibex core's instruction and data interfaces and the SoC AHB-Lite fabric. It arbitrates the two ports onto one AHB master, registers write data into the AHB data phase and maps HRESP onto per-port error flags. It derives HSIZE and byte offset from any legal byte-enable pattern, and answers illegal byte enables locally without a bus access. Next-generation replacement for the fixed-32-bit, no-error Ibex bus adapter.

---
 rtl/obi_ahb_bridge.sv | 188 ++++++++++++++++++
 tb/tb_obi_ahb_bridge.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/obi_ahb_bridge.sv
// obi_ahb_bridge: two-port OBI (instruction + data) to AHB-Lite master bridge.
// Arbitrates both ports onto one non-pipelined AHB master. Write data is
// registered into the data phase. HRESP is mapped onto the per-port err flags.
// Illegal data byte enables are answered locally with an error and do not
// start a bus access.
// Optional feature: define OBI_AHB_RR_ARB_EN for round-robin arbitration.
// Without it, arbitration is fixed priority and the data port always wins.
//
// state | meaning
// IDLE  | no transfer, waiting for a request
// ADDR  | AHB address phase for port src (gnt when it advances)
// DATA  | AHB data phase, waiting for HREADY, then rvalid to src
// LERR  | local error response for an illegal data_be_i
module obi_ahb_bridge #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic            HCLK,
    input  logic            HRESETn,
    input  logic            instr_req_i,
    output logic            instr_gnt_o,
    output logic            instr_rvalid_o,
    input  logic [AW-1:0]   instr_addr_i,
    output logic [DW-1:0]   instr_rdata_o,
    output logic            instr_err_o,
    input  logic            data_req_i,
    output logic            data_gnt_o,
    output logic            data_rvalid_o,
    input  logic            data_we_i,
    input  logic [DW/8-1:0] data_be_i,
    input  logic [AW-1:0]   data_addr_i,
    input  logic [DW-1:0]   data_wdata_i,
    output logic [DW-1:0]   data_rdata_o,
    output logic            data_err_o,
    output logic [AW-1:0]   HADDR,
    output logic [2:0]      HSIZE,
    output logic [1:0]      HTRANS,
    output logic            HWRITE,
    output logic [3:0]      HPROT,
    output logic [DW-1:0]   HWDATA,
    input  logic [DW-1:0]   HRDATA,
    input  logic            HREADY,
    input  logic            HRESP
);
    localparam int BW    = DW / 8;
    localparam int BW_LG = $clog2(BW);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, LERR} state_t;

    state_t           state_q, state_d;
    logic             src_q, src_d;     // 1 = data port, 0 = instruction port
    logic [DW-1:0]    wdata_q;
    logic             be_legal;
    logic [2:0]       be_size;
    logic [BW_LG-1:0] be_off;
    logic             any_req;
    logic             arb_data;

    assign any_req = instr_req_i | data_req_i;

`ifdef OBI_AHB_RR_ARB_EN
    logic last_data_q;

    // On a tie, the port that was not granted last wins.
    assign arb_data = data_req_i & (~instr_req_i | ~last_data_q);

    // Remember which port received the most recent grant.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn)
            last_data_q <= 1'b0;
        else if (instr_gnt_o || data_gnt_o)
            last_data_q <= data_gnt_o;
    end
`else
    assign arb_data = data_req_i;
`endif

    // Match data_be_i against every naturally aligned power-of-two run of ones.
    always_comb begin
        be_legal = 1'b0;
        be_size  = '0;
        be_off   = '0;
        for (int s = 0; s <= BW_LG; s++) begin
            for (int o = 0; o < BW; o++) begin
                if ((o % (1 << s)) == 0 && (o + (1 << s)) <= BW &&
                    data_be_i == BW'(((1 << (1 << s)) - 1) << o)) begin
                    be_legal = 1'b1;
                    be_size  = 3'(s);
                    be_off   = BW_LG'(o);
                end
            end
        end
    end

    // State, source port and write-data registers.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= IDLE;
            src_q   <= 1'b0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            if (state_q == ADDR && src_q && HREADY)
                wdata_q <= data_wdata_i;
        end
    end

    // Next-state logic and all OBI/AHB outputs.
    always_comb begin
        state_d        = state_q;
        src_d          = src_q;
        instr_gnt_o    = 1'b0;
        instr_rvalid_o = 1'b0;
        instr_rdata_o  = '0;
        instr_err_o    = 1'b0;
        data_gnt_o     = 1'b0;
        data_rvalid_o  = 1'b0;
        data_rdata_o   = '0;
        data_err_o     = 1'b0;
        HADDR          = '0;
        HSIZE          = '0;
        HTRANS         = 2'b00;
        HWRITE         = 1'b0;
        HPROT          = '0;
        HWDATA         = '0;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d = ADDR;
                    src_d   = arb_data;
                end
            end
            ADDR: begin
                if (src_q) begin
                    if (!be_legal) begin
                        data_gnt_o = 1'b1;
                        state_d    = LERR;
                    end else begin
                        HTRANS = 2'b10;
                        HADDR  = data_addr_i | AW'(be_off);
                        HSIZE  = be_size;
                        HWRITE = data_we_i;
                        HPROT  = 4'b0011;
                        if (HREADY) begin
                            data_gnt_o = 1'b1;
                            state_d    = DATA;
                        end
                    end
                end else begin
                    HTRANS = 2'b10;
                    HADDR  = instr_addr_i;
                    HSIZE  = 3'(BW_LG);
                    HPROT  = 4'b0010;
                    if (HREADY) begin
                        instr_gnt_o = 1'b1;
                        state_d     = DATA;
                    end
                end
            end
            DATA: begin
                HWDATA = wdata_q;
                if (HREADY) begin
                    if (src_q) begin
                        data_rvalid_o = 1'b1;
                        data_rdata_o  = HRDATA;
                        data_err_o    = HRESP;
                    end else begin
                        instr_rvalid_o = 1'b1;
                        instr_rdata_o  = HRDATA;
                        instr_err_o    = HRESP;
                    end
                    state_d = any_req ? ADDR : IDLE;
                    if (any_req)
                        src_d = arb_data;
                end
            end
            LERR: begin
                data_rvalid_o = 1'b1;
                data_err_o    = 1'b1;
                state_d       = any_req ? ADDR : IDLE;
                if (any_req)
                    src_d = arb_data;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_obi_ahb_bridge.sv
// tb_obi_ahb_bridge: directed and randomized checks of obi_ahb_bridge (DW=32)
// against a transaction-level reference model. Define OBI_AHB_RR_ARB_EN
// together with the RTL to check the round-robin build.
`timescale 1ns/1ps
module tb_obi_ahb_bridge;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = DW / 8;

    logic          HCLK = 1'b0;
    logic          HRESETn = 1'b0;
    logic          instr_req_i = 1'b0;
    logic          instr_gnt_o;
    logic          instr_rvalid_o;
    logic [AW-1:0] instr_addr_i = '0;
    logic [DW-1:0] instr_rdata_o;
    logic          instr_err_o;
    logic          data_req_i = 1'b0;
    logic          data_gnt_o;
    logic          data_rvalid_o;
    logic          data_we_i = 1'b0;
    logic [BW-1:0] data_be_i = '0;
    logic [AW-1:0] data_addr_i = '0;
    logic [DW-1:0] data_wdata_i = '0;
    logic [DW-1:0] data_rdata_o;
    logic          data_err_o;
    logic [AW-1:0] HADDR;
    logic [2:0]    HSIZE;
    logic [1:0]    HTRANS;
    logic          HWRITE;
    logic [3:0]    HPROT;
    logic [DW-1:0] HWDATA;
    logic [DW-1:0] HRDATA = '0;
    logic          HREADY = 1'b1;
    logic          HRESP = 1'b0;

    obi_ahb_bridge #(.AW(AW), .DW(DW)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .instr_req_i(instr_req_i), .instr_gnt_o(instr_gnt_o),
        .instr_rvalid_o(instr_rvalid_o), .instr_addr_i(instr_addr_i),
        .instr_rdata_o(instr_rdata_o), .instr_err_o(instr_err_o),
        .data_req_i(data_req_i), .data_gnt_o(data_gnt_o),
        .data_rvalid_o(data_rvalid_o), .data_we_i(data_we_i),
        .data_be_i(data_be_i), .data_addr_i(data_addr_i),
        .data_wdata_i(data_wdata_i), .data_rdata_o(data_rdata_o),
        .data_err_o(data_err_o),
        .HADDR(HADDR), .HSIZE(HSIZE), .HTRANS(HTRANS), .HWRITE(HWRITE),
        .HPROT(HPROT), .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY),
        .HRESP(HRESP)
    );

    always #5 HCLK = ~HCLK;

    int n_tests = 0;
    int n_fail  = 0;
    bit lg_data = 1'b0;   // model: last grant went to the data port

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference byte-enable rule: popcount 1/2/4, contiguous, aligned to its size.
    function automatic void be_model(input logic [3:0] be, output bit legal,
                                     output logic [2:0] size, output logic [1:0] off);
        int pc, low;
        pc  = $countones(be);
        low = 0;
        for (int i = BW - 1; i >= 0; i--)
            if (be[i]) low = i;
        legal = 1'b0;
        if (pc == 1 || pc == 2 || pc == 4)
            legal = ((low % pc) == 0) && (be == 4'(((1 << pc) - 1) << low));
        size = (pc == 4) ? 3'd2 : (pc == 2) ? 3'd1 : 3'd0;
        off  = 2'(low);
    endfunction

    function automatic bit tie_winner_data();
`ifdef OBI_AHB_RR_ARB_EN
        return !lg_data;
`else
        return 1'b1;
`endif
    endfunction

    task automatic check_idle_outputs(input string tag);
        check({tag, ".gnt"},    {instr_gnt_o, data_gnt_o}, 2'b00);
        check({tag, ".rvalid"}, {instr_rvalid_o, data_rvalid_o}, 2'b00);
        check({tag, ".err"},    {instr_err_o, data_err_o}, 2'b00);
        check({tag, ".rdata"},  {instr_rdata_o, data_rdata_o}, 64'h0);
        check({tag, ".htrans"}, HTRANS, 2'b00);
        check({tag, ".haddr"},  HADDR, 32'h0);
        check({tag, ".hsize"},  HSIZE, 3'b000);
        check({tag, ".hwrite"}, HWRITE, 1'b0);
        check({tag, ".hprot"},  HPROT, 4'h0);
        check({tag, ".hwdata"}, HWDATA, 32'h0);
    endtask

    task automatic do_reset();
        @(negedge HCLK);
        instr_req_i = 1'b0;
        data_req_i  = 1'b0;
        HREADY      = 1'b1;
        HRESP       = 1'b0;
        HRESETn     = 1'b0;
        @(negedge HCLK);
        #1;
        check_idle_outputs("reset");
        @(negedge HCLK);
        HRESETn = 1'b1;
        lg_data = 1'b0;
    endtask

    // One isolated transfer: request, address phase, data phase, idle.
    task automatic do_txn(input bit is_data, input bit we, input logic [31:0] addr,
                          input logic [3:0] be, input logic [31:0] wd, input logic [31:0] rd,
                          input int waits, input bit err, input string tag);
        bit          legal;
        logic [2:0]  sz;
        logic [1:0]  off;
        bit          wr;
        if (is_data) be_model(be, legal, sz, off);
        else begin legal = 1'b1; sz = 3'd2; off = 2'd0; end
        wr = is_data && we;
        // request cycle: not yet granted
        @(negedge HCLK);
        HREADY = 1'b1;
        HRESP  = 1'b0;
        HRDATA = $urandom;
        if (is_data) begin
            data_req_i = 1'b1; data_we_i = we; data_addr_i = addr;
            data_be_i = be; data_wdata_i = wd;
        end else begin
            instr_req_i = 1'b1; instr_addr_i = addr;
        end
        #1;
        check({tag, ".gnt_early"}, {instr_gnt_o, data_gnt_o}, 2'b00);
        // address phase
        @(negedge HCLK);
        #1;
        check({tag, ".gnt"}, {instr_gnt_o, data_gnt_o}, is_data ? 2'b01 : 2'b10);
        if (legal) begin
            check({tag, ".htrans"}, HTRANS, 2'b10);
            check({tag, ".haddr"},  HADDR, addr | {30'h0, off});
            check({tag, ".hsize"},  HSIZE, sz);
            check({tag, ".hwrite"}, HWRITE, wr);
            check({tag, ".hprot"},  HPROT, is_data ? 4'b0011 : 4'b0010);
        end else begin
            check({tag, ".htrans_lerr"}, HTRANS, 2'b00);
        end
        lg_data = is_data;
        // data phase (or local error response)
        @(negedge HCLK);
        instr_req_i  = 1'b0;
        data_req_i   = 1'b0;
        data_wdata_i = ~wd;
        if (!legal) begin
            HRDATA = 32'hFFFF_FFFF;
            #1;
            check({tag, ".lerr_rvalid"}, {instr_rvalid_o, data_rvalid_o}, 2'b01);
            check({tag, ".lerr_err"},    data_err_o, 1'b1);
            check({tag, ".lerr_rdata"},  data_rdata_o, 32'h0);
            check({tag, ".lerr_htrans"}, HTRANS, 2'b00);
        end else begin
            for (int w = 0; w < waits; w++) begin
                HREADY = 1'b0;
                HRESP  = err && (w == waits - 1);
                #1;
                check({tag, ".wait_rvalid"}, {instr_rvalid_o, data_rvalid_o}, 2'b00);
                check({tag, ".wait_err"},    {instr_err_o, data_err_o}, 2'b00);
                if (wr) check({tag, ".wait_hwdata"}, HWDATA, wd);
                @(negedge HCLK);
            end
            HREADY = 1'b1;
            HRESP  = err;
            HRDATA = rd;
            #1;
            check({tag, ".rvalid"}, {instr_rvalid_o, data_rvalid_o}, is_data ? 2'b01 : 2'b10);
            if (is_data) begin
                check({tag, ".rdata"},  data_rdata_o, rd);
                check({tag, ".err"},    data_err_o, err);
                check({tag, ".other_rdata"}, instr_rdata_o, 32'h0);
            end else begin
                check({tag, ".rdata"},  instr_rdata_o, rd);
                check({tag, ".err"},    instr_err_o, err);
                check({tag, ".other_rdata"}, data_rdata_o, 32'h0);
            end
            if (wr) check({tag, ".hwdata"}, HWDATA, wd);
        end
        // back to idle
        @(negedge HCLK);
        HRESP  = 1'b0;
        HREADY = 1'b1;
        #1;
        check({tag, ".idle_hwdata"}, HWDATA, 32'h0);
        check({tag, ".idle_htrans"}, HTRANS, 2'b00);
        check({tag, ".idle_rvalid"}, {instr_rvalid_o, data_rvalid_o}, 2'b00);
    endtask

    initial begin
        logic [3:0]  legal_be [7];
        logic [31:0] rdv;
        bit          exp_d;
        legal_be = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};

        do_reset();

        // single fetch
        do_txn(1'b0, 1'b0, 32'h100, 4'hF, 32'h0, 32'hDEADBEEF, 0, 1'b0, "fetch");
        // byte write with three wait states
        do_txn(1'b1, 1'b1, 32'h200, 4'b0100, 32'h00AB0000, 32'h0, 3, 1'b0, "bytewr");
        // illegal byte enables, including all-zero
        do_txn(1'b1, 1'b0, 32'h204, 4'b0110, 32'h0, 32'h0, 0, 1'b0, "illegal_0110");
        do_txn(1'b1, 1'b1, 32'h208, 4'b0000, 32'h1234, 32'h0, 0, 1'b0, "illegal_0000");
        // halfword write to upper half
        do_txn(1'b1, 1'b1, 32'h20C, 4'b1100, 32'hBEEF0000, 32'h0, 1, 1'b0, "halfwr");
        // two-cycle AHB error, then a clean fetch
        do_txn(1'b1, 1'b0, 32'h300, 4'hF, 32'h0, 32'h55AA55AA, 1, 1'b1, "ahb_err");
        do_txn(1'b0, 1'b0, 32'h104, 4'hF, 32'h0, 32'h13579BDF, 0, 1'b0, "fetch_after_err");

        // simultaneous continuous requests on both ports
        do_reset();
        @(negedge HCLK);
        instr_req_i = 1'b1; instr_addr_i = 32'h500;
        data_req_i = 1'b1; data_we_i = 1'b0; data_addr_i = 32'h600; data_be_i = 4'hF;
        HREADY = 1'b1; HRESP = 1'b0;
        #1;
        check("arb.gnt_early", {instr_gnt_o, data_gnt_o}, 2'b00);
        for (int k = 0; k < 4; k++) begin
            @(negedge HCLK);
            #1;
            exp_d = tie_winner_data();
            check($sformatf("arb%0d.gnt", k), {instr_gnt_o, data_gnt_o}, {!exp_d, exp_d});
            check($sformatf("arb%0d.haddr", k), HADDR, exp_d ? 32'h600 : 32'h500);
            lg_data = exp_d;
            @(negedge HCLK);
            rdv    = $urandom;
            HRDATA = rdv;
            if (k == 3) begin instr_req_i = 1'b0; data_req_i = 1'b0; end
            #1;
            check($sformatf("arb%0d.rvalid", k), {instr_rvalid_o, data_rvalid_o}, {!exp_d, exp_d});
            check($sformatf("arb%0d.rdata", k), exp_d ? data_rdata_o : instr_rdata_o, rdv);
        end
        @(negedge HCLK);
        #1;
        check("arb.end_htrans", HTRANS, 2'b00);

        // reset asserted during a data-phase wait state
        @(negedge HCLK);
        data_req_i = 1'b1; data_we_i = 1'b1; data_addr_i = 32'h400; data_be_i = 4'hF;
        data_wdata_i = 32'hCAFEF00D; HREADY = 1'b1;
        @(negedge HCLK);
        #1;
        check("rst_mid.gnt", data_gnt_o, 1'b1);
        @(negedge HCLK);
        data_req_i = 1'b0; HREADY = 1'b0;
        #1;
        check("rst_mid.hwdata_before", HWDATA, 32'hCAFEF00D);
        #1;
        HRESETn = 1'b0;
        #1;
        check("rst_mid.htrans", HTRANS, 2'b00);
        check("rst_mid.rvalid", {instr_rvalid_o, data_rvalid_o}, 2'b00);
        check("rst_mid.hwdata", HWDATA, 32'h0);
        @(negedge HCLK);
        HREADY = 1'b1;
        #1;
        check("rst_mid.rvalid_held", {instr_rvalid_o, data_rvalid_o}, 2'b00);
        @(negedge HCLK);
        HRESETn = 1'b1;
        lg_data = 1'b0;
        do_txn(1'b1, 1'b0, 32'h404, 4'b0011, 32'h0, 32'h87654321, 2, 1'b0, "after_rst");

        // randomized isolated transfers
        for (int n = 0; n < 40; n++) begin
            bit          isd;
            logic [3:0]  be;
            isd = 1'($urandom_range(0, 1));
            be  = ($urandom_range(0, 1) == 1) ? legal_be[$urandom_range(0, 6)] : 4'($urandom);
            do_txn(isd, 1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC, be, $urandom,
                   $urandom, int'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0),
                   $sformatf("rnd%0d", n));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
